irq_ctrl: RTL and testbench



---
 rtl/irq_ctrl_pkg.sv | 42 ++++
 rtl/irq_ctrl_sync_edge.sv | 37 +++
 rtl/irq_ctrl.sv | 152 +++++++++++++++
 tb/tb_irq_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : irq_ctrl_pkg
// Description : Shared constants for the interrupt controller: register
//               offsets, register reset values, the "no interrupt" vector
//               code and a lowest-set-bit helper.
// Revision    : 1.0 - initial release
// ============================================================================
package irq_ctrl_pkg;

    // Byte offsets of the five registers inside the window.
    localparam logic [4:0] OFF_PENDING = 5'h00;
    localparam logic [4:0] OFF_MASK    = 5'h04;
    localparam logic [4:0] OFF_MODE    = 5'h08;
    localparam logic [4:0] OFF_CLEAR   = 5'h0C;
    localparam logic [4:0] OFF_VECTOR  = 5'h10;

    // Size of the register window in bytes.
    localparam logic [31:0] WINDOW_BYTES = 32'h0000_0014;

    // Reset values; the top level keeps only the low NSRC bits.
    localparam logic [31:0] MASK_RST = 32'hFFFF_FFFF;
    localparam logic [31:0] MODE_RST = 32'h0000_0000;

    // VECTOR read value when no unmasked interrupt is pending.
    localparam logic [31:0] VEC_NONE = 32'hFFFF_FFFF;

    // Index of the lowest set bit (lowest index = highest priority),
    // or VEC_NONE when the input is all zeros.
    function automatic logic [31:0] lowest_set(input logic [31:0] v);
        logic [31:0] idx;
        idx = VEC_NONE;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) begin
                idx = 32'(i);
            end
        end
        return idx;
    endfunction

endpackage : irq_ctrl_pkg
`default_nettype wire

// File: rtl/irq_ctrl_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : irq_sync_edge
// Description : Two-flop synchronizer for one asynchronous interrupt line
//               plus a history flop for rising-edge detection.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic lvl,
    output logic rise
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    // Synchronizer chain s1 -> s2, with s3 holding the previous s2 value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= d;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign lvl  = r_s2;
    assign rise = r_s2 & ~r_s3;

endmodule : irq_sync_edge
`default_nettype wire

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : irq_ctrl
// Description : Memory-mapped programmable interrupt controller. Synchronises
//               each source, latches edge or level requests into PENDING,
//               applies MASK and presents hw_int plus a priority vector.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_ctrl #(
    parameter int          NSRC = 6,
    parameter logic [31:0] BASE = 32'h0000_7F30
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_in,
    input  logic [31:0]     addr,
    input  logic            we,
    input  logic [3:0]      byteen,
    input  logic [31:0]     wdata,
    output logic            sel,
    output logic [31:0]     rdata,
    output logic [NSRC-1:0] hw_int,
    output logic            irq_any
);

    import irq_ctrl_pkg::*;

    logic [NSRC-1:0] r_pending;
    logic [NSRC-1:0] r_mask;
    logic [NSRC-1:0] r_mode;

    logic [NSRC-1:0] w_lvl;
    logic [NSRC-1:0] w_rise;
    logic [NSRC-1:0] w_clr;
    logic [NSRC-1:0] w_mode_chg;
    logic [NSRC-1:0] w_pending_nxt;
    logic [NSRC-1:0] w_wdata_n;

    logic [31:0]     w_off;
    logic [4:0]      w_reg;
    logic            w_wr;
    logic            w_wr_mask;
    logic            w_wr_mode;
    logic            w_wr_clr;

    logic [31:0]     w_pending_ext;
    logic [31:0]     w_mask_ext;
    logic [31:0]     w_mode_ext;
    logic [31:0]     w_hw_ext;
    logic [31:0]     w_vector;
    logic            w_unused;

    // ------------------------------------------------------------------
    // Per-source synchronizer and edge detector
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
            irq_sync_edge u_sync (
                .clk   (clk),
                .reset (reset),
                .d     (irq_in[gi]),
                .lvl   (w_lvl[gi]),
                .rise  (w_rise[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Address decode. Unsigned subtraction makes addresses below BASE wrap
    // to huge offsets, so one compare covers both window bounds.
    // ------------------------------------------------------------------
    assign w_off     = addr - BASE;
    assign sel       = (w_off < WINDOW_BYTES);
    assign w_reg     = {w_off[4:2], 2'b00};
    assign w_wr      = we && sel && (byteen == 4'hF);
    assign w_wr_mask = w_wr && (w_reg == OFF_MASK);
    assign w_wr_mode = w_wr && (w_reg == OFF_MODE);
    assign w_wr_clr  = w_wr && (w_reg == OFF_CLEAR);
    assign w_wdata_n = wdata[NSRC-1:0];

    assign w_clr      = w_wr_clr  ? w_wdata_n : '0;
    assign w_mode_chg = w_wr_mode ? (w_wdata_n ^ r_mode) : '0;

    // Next pending value: a mode flip drops the bit so no stale latch
    // survives; edge mode lets a new rise win over a same-cycle clear.
    always_comb begin
        w_pending_nxt = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (w_mode_chg[i]) begin
                w_pending_nxt[i] = 1'b0;
            end else if (r_mode[i]) begin
                w_pending_nxt[i] = (r_pending[i] & ~w_clr[i]) | w_rise[i];
            end else begin
                w_pending_nxt[i] = w_lvl[i];
            end
        end
    end

    // Pending, mask and mode registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending <= '0;
            r_mask    <= MASK_RST[NSRC-1:0];
            r_mode    <= MODE_RST[NSRC-1:0];
        end else begin
            r_pending <= w_pending_nxt;
            if (w_wr_mask) begin
                r_mask <= w_wdata_n;
            end
            if (w_wr_mode) begin
                r_mode <= w_wdata_n;
            end
        end
    end

    assign hw_int  = r_pending & r_mask;
    assign irq_any = |hw_int;

    // Zero-extend the NSRC-wide fields to the 32-bit bus width.
    always_comb begin
        w_pending_ext             = '0;
        w_mask_ext                = '0;
        w_mode_ext                = '0;
        w_hw_ext                  = '0;
        w_pending_ext[NSRC-1:0]   = r_pending;
        w_mask_ext[NSRC-1:0]      = r_mask;
        w_mode_ext[NSRC-1:0]      = r_mode;
        w_hw_ext[NSRC-1:0]        = hw_int;
    end

    assign w_vector = lowest_set(w_hw_ext);

    // Combinational read mux; misses and offsets past VECTOR read zero.
    always_comb begin
        rdata = '0;
        if (sel) begin
            case (w_reg)
                OFF_PENDING: rdata = w_pending_ext;
                OFF_MASK:    rdata = w_mask_ext;
                OFF_MODE:    rdata = w_mode_ext;
                OFF_CLEAR:   rdata = '0;
                OFF_VECTOR:  rdata = w_vector;
                default:     rdata = '0;
            endcase
        end
    end

    // Bus bits that the register file does not use.
    assign w_unused = ^{wdata, w_off};

endmodule : irq_ctrl
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_ctrl
// Description : Directed self-checking bench for irq_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_ctrl;

    localparam int          NSRC = 6;
    localparam logic [31:0] BASE = 32'h0000_7F30;
    localparam logic [31:0] A_PEND = BASE + 32'h00;
    localparam logic [31:0] A_MASK = BASE + 32'h04;
    localparam logic [31:0] A_MODE = BASE + 32'h08;
    localparam logic [31:0] A_CLR  = BASE + 32'h0C;
    localparam logic [31:0] A_VEC  = BASE + 32'h10;

    logic            clk;
    logic            reset;
    logic [NSRC-1:0] irq_in;
    logic [31:0]     addr;
    logic            we;
    logic [3:0]      byteen;
    logic [31:0]     wdata;
    logic            sel;
    logic [31:0]     rdata;
    logic [NSRC-1:0] hw_int;
    logic            irq_any;

    int checks   = 0;
    int failures = 0;

    irq_ctrl #(.NSRC(NSRC), .BASE(BASE)) dut (
        .clk     (clk),
        .reset   (reset),
        .irq_in  (irq_in),
        .addr    (addr),
        .we      (we),
        .byteen  (byteen),
        .wdata   (wdata),
        .sel     (sel),
        .rdata   (rdata),
        .hw_int  (hw_int),
        .irq_any (irq_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Combinational read: present the address away from the clock edge.
    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, rdata, exp);
        addr = 32'h0;
    endtask

    // One-cycle bus write, launched just after a falling edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        addr   = a;
        wdata  = d;
        byteen = be;
        we     = 1'b1;
        @(negedge clk);
        we     = 1'b0;
        addr   = 32'h0;
        wdata  = 32'h0;
        byteen = 4'h0;
    endtask

    initial begin
        reset  = 1'b0;
        irq_in = 6'h3F;
        addr   = 32'h0;
        we     = 1'b0;
        byteen = 4'h0;
        wdata  = 32'h0;

        // ---------------- reset ----------------
        cyc(3);
        chk("rst_hw_int", {26'h0, hw_int}, 32'h0);
        chk("rst_irq_any", {31'h0, irq_any}, 32'h0);
        rd_chk("rst_mask", A_MASK, 32'h0000_003F);
        rd_chk("rst_mode", A_MODE, 32'h0);
        rd_chk("rst_pending", A_PEND, 32'h0);
        reset = 1'b1;
        cyc(1);
        chk("post_rst_c1", {26'h0, hw_int}, 32'h0);
        cyc(1);
        chk("post_rst_c2", {26'h0, hw_int}, 32'h0);
        cyc(1);
        chk("post_rst_c3", {26'h0, hw_int}, 32'h3F);
        chk("post_rst_any", {31'h0, irq_any}, 32'h1);
        rd_chk("post_rst_vec", A_VEC, 32'h0);

        // ---------------- address decode ----------------
        addr = A_VEC;   #1; chk("sel_vec", {31'h0, sel}, 32'h1);
        addr = BASE + 32'h14; #1; chk("sel_past", {31'h0, sel}, 32'h0);
        addr = BASE - 32'h4;  #1; chk("sel_below", {31'h0, sel}, 32'h0);
        rd_chk("rd_past", BASE + 32'h14, 32'h0);
        rd_chk("rd_clear", A_CLR, 32'h0);

        // ---------------- edge latch and clear ----------------
        irq_in = 6'h00;
        cyc(4);
        wr(A_MODE, 32'h01, 4'hF);
        rd_chk("mode_rb", A_MODE, 32'h01);
        irq_in[0] = 1'b1;
        cyc(2);
        irq_in[0] = 1'b0;
        cyc(3);
        rd_chk("edge_pend", A_PEND, 32'h01);
        rd_chk("edge_vec", A_VEC, 32'h0);
        wr(A_CLR, 32'h01, 4'hF);
        rd_chk("edge_clr", A_PEND, 32'h0);
        chk("edge_clr_any", {31'h0, irq_any}, 32'h0);
        rd_chk("vec_none", A_VEC, 32'hFFFF_FFFF);

        // ---------------- set-wins collision ----------------
        wr(A_MODE, 32'h03, 4'hF);
        irq_in[1] = 1'b1;
        cyc(2);                     // rise of bit 1 now feeds the next edge
        wr(A_CLR, 32'h02, 4'hF);    // clear sampled at that same edge
        rd_chk("set_wins", A_PEND, 32'h02);
        wr(A_CLR, 32'h02, 4'hF);
        cyc(3);                     // input still held high: no new edge
        rd_chk("held_one_edge", A_PEND, 32'h0);
        irq_in[1] = 1'b0;
        cyc(2);

        // ---------------- mask ----------------
        wr(A_MASK, 32'h3B, 4'hF);
        irq_in[2] = 1'b1;
        cyc(4);
        chk("mask_hw_int", {26'h0, hw_int}, 32'h0);
        chk("mask_any", {31'h0, irq_any}, 32'h0);
        rd_chk("mask_pend", A_PEND, 32'h04);
        wr(A_MASK, 32'h3F, 4'hF);
        chk("unmask_hw_int", {26'h0, hw_int}, 32'h04);
        rd_chk("unmask_vec", A_VEC, 32'h2);
        irq_in[2] = 1'b0;
        cyc(4);
        rd_chk("level_drop", A_PEND, 32'h0);

        // ---------------- priority and partial writes ----------------
        irq_in = 6'h28;
        cyc(4);
        rd_chk("prio_vec", A_VEC, 32'h3);
        chk("prio_hw_int", {26'h0, hw_int}, 32'h28);
        wr(A_MASK, 32'h00, 4'h1);
        rd_chk("partial_mask", A_MASK, 32'h3F);
        wr(A_PEND, 32'h00, 4'hF);
        rd_chk("pend_ro", A_PEND, 32'h28);
        wr(A_MASK, 32'h37, 4'hF);
        rd_chk("prio_vec5", A_VEC, 32'h5);
        wr(A_MASK, 32'h00, 4'hF);
        rd_chk("allmask_vec", A_VEC, 32'hFFFF_FFFF);
        rd_chk("allmask_pend", A_PEND, 32'h28);
        wr(A_MASK, 32'h3F, 4'hF);
        irq_in = 6'h00;
        cyc(4);

        // ---------------- mode change ----------------
        wr(A_MODE, 32'h13, 4'hF);
        irq_in[4] = 1'b1;
        cyc(2);
        irq_in[4] = 1'b0;
        cyc(3);
        rd_chk("mc_latched", A_PEND, 32'h10);
        wr(A_MODE, 32'h03, 4'hF);
        rd_chk("mc_cleared", A_PEND, 32'h0);

        // ---------------- reset mid-operation ----------------
        irq_in = 6'h20;
        cyc(4);
        rd_chk("mid_pend", A_PEND, 32'h20);
        reset = 1'b0;
        #1;
        chk("mid_rst_hw", {26'h0, hw_int}, 32'h0);
        rd_chk("mid_rst_pend", A_PEND, 32'h0);
        rd_chk("mid_rst_mode", A_MODE, 32'h0);
        cyc(2);
        reset = 1'b1;
        irq_in = 6'h00;
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_irq_ctrl
`default_nettype wire
